data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
- Sits between the pipeline memory stage (ALUResultM / WriteDataM / MemWriteM) and the backing data memory.
- Read hits are served combinationally in the same cycle.
- Read misses and all writes stall the pipeline while a request/ack transaction completes on the memory side.

---
 rtl/data_cache.sv | 165 ++++++++++++++++
 tb/tb_data_cache.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache, one 32-bit word per line.
// Latency : load hit 0 cycles; load miss stalls (cycles to mem_ack) + 1; store stalls until mem_ack, then retires in DONE.
// Backpress: cpu_stall holds the pipeline, which keeps request inputs stable; mem_req holds until mem_ack.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_req/we/addr      memory-stage access (addr[1:0] ignored)
//   cpu_wdata/be         store data and byte enables (lane aligned)
//   cpu_rdata            full load word; combinational on a load hit, otherwise holds the last hit value
//   cpu_stall            pipeline hold
//   mem_req/we/addr      registered backing-memory request, word aligned
//   mem_wdata/be         registered write data and byte enables
//   mem_rdata/ack        backing-memory read data and one-cycle completion pulse
module data_cache #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tagRam  [LINES];
    logic [DATA_WIDTH-1:0]   dataRam [LINES];

    logic [INDEX_WIDTH-1:0]  index;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic                    loadHit;
    logic [DATA_WIDTH-1:0]   lineData;
    logic [DATA_WIDTH-1:0]   mergedData;
    logic [DATA_WIDTH-1:0]   rdataHold;

    logic                    memReq;
    logic                    memWe;
    logic [ADDR_WIDTH-1:0]   memAddr;
    logic [DATA_WIDTH-1:0]   memWdata;
    logic [3:0]              memBe;

    // Byte offset bits never select anything in a one-word-per-line cache.
    logic unusedOffset;
    assign unusedOffset = ^cpu_addr[1:0];

    assign index    = cpu_addr[INDEX_WIDTH+1:2];
    assign tag      = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign lineData = dataRam[index];
    assign hit      = valid[index] && (tagRam[index] == tag);
    assign loadHit  = (state == IDLE) && cpu_req && !cpu_we && hit;

    // Load hits bypass the hold register so they return in the same cycle;
    // mem_rdata only reaches cpu_rdata through dataRam, never combinationally.
    assign cpu_rdata = loadHit ? lineData : rdataHold;

    assign mem_req   = memReq;
    assign mem_we    = memWe;
    assign mem_addr  = memAddr;
    assign mem_wdata = memWdata;
    assign mem_be    = memBe;

    always_comb begin
        cpu_stall = 1'b0;
        unique case (state)
            IDLE:  cpu_stall = cpu_req && (cpu_we || !hit);
            FILL:  cpu_stall = 1'b1;
            WRITE: cpu_stall = 1'b1;
            DONE:  cpu_stall = 1'b0;
        endcase
    end

    // Store-hit merge: only enabled byte lanes take the new data.
    always_comb begin
        mergedData = lineData;
        for (int b = 0; b < 4; b++) begin
            if (cpu_be[b]) begin
                mergedData[8*b +: 8] = cpu_wdata[8*b +: 8];
            end
        end
    end

    // Control, valid bits and registered memory-side request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWdata  <= '0;
            memBe     <= '0;
            rdataHold <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        memAddr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        memWdata <= cpu_wdata;
                        memBe    <= cpu_be;
                        if (cpu_we) begin
                            state  <= WRITE;
                            memReq <= 1'b1;
                            memWe  <= 1'b1;
                        end else if (!hit) begin
                            state  <= FILL;
                            memReq <= 1'b1;
                            memWe  <= 1'b0;
                        end else begin
                            rdataHold <= lineData;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[index] <= 1'b1;
                        memReq       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; reset only blocks a coincident ack write.
    always_ff @(posedge clk) begin
        if (!rst && mem_ack) begin
            if (state == FILL) begin
                tagRam[index]  <= tag;
                dataRam[index] <= mem_rdata;
            end else if (state == WRITE && hit) begin
                dataRam[index] <= mergedData;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    // Scoreboards: expected load results and expected memory-side requests
    // {we, addr, wdata, be}; loads compare only we and addr.
    logic [31:0] rdQ  [$];
    logic [68:0] memQ [$];

    data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_WIDTH(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic unexpectedReq(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=memory request expected=none queued", tag);
    endtask

    // Load: a miss waits ackDelay FILL cycles, then the memory acks with fillData.
    task automatic doLoad(input logic [31:0] addr, input bit expMiss, input int ackDelay,
                          input logic [31:0] fillData, input logic [31:0] expData);
        int stallCycles;
        logic [68:0] expReq;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        cpu_be   = 4'hF;
        rdQ.push_back(expData);
        if (expMiss) memQ.push_back({1'b0, addr & 32'hFFFF_FFFC, 36'h0});
        #1;
        check("ld_stall", cpu_stall, expMiss);
        if (cpu_stall) begin
            stallCycles = 1;
            tick();
            check("ld_mem_req", mem_req, 1'b1);
            if (memQ.size() > 0) begin
                expReq = memQ.pop_front();
                check("ld_mem_op", {mem_we, mem_addr, 36'h0}, expReq);
            end else begin
                unexpectedReq("ld_mem_op");
            end
            if (cpu_stall) stallCycles++;
            for (int i = 1; i < ackDelay; i++) begin
                tick();
                if (cpu_stall) stallCycles++;
            end
            check("ld_mem_req_hold", {mem_req, mem_addr}, {1'b1, addr & 32'hFFFF_FFFC});
            mem_ack   = 1'b1;
            mem_rdata = fillData;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            check("ld_stall_cycles", stallCycles, ackDelay + 1);
            check("ld_release", cpu_stall, 1'b0);
        end
        check("ld_mem_idle", mem_req, 1'b0);
        check("ld_data", cpu_rdata, rdQ.pop_front());
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input int ackDelay);
        logic [68:0] expReq;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_be    = be;
        memQ.push_back({1'b1, addr & 32'hFFFF_FFFC, data, be});
        #1;
        check("st_stall", cpu_stall, 1'b1);
        tick();
        check("st_mem_req", mem_req, 1'b1);
        if (memQ.size() > 0) begin
            expReq = memQ.pop_front();
            check("st_mem_op", {mem_we, mem_addr, mem_wdata, mem_be}, expReq);
        end else begin
            unexpectedReq("st_mem_op");
        end
        for (int i = 1; i < ackDelay; i++) tick();
        check("st_hold", {cpu_stall, mem_req, mem_we}, 3'b111);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        // DONE: store retires this cycle, request already dropped.
        check("st_done", {cpu_stall, mem_req}, 2'b00);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("st_idle", cpu_stall, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_be    = 4'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        tick();

        // Cold miss then hit.
        doLoad(32'h0000_0100, 1'b1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        doLoad(32'h0000_0100, 1'b0, 0, 32'h0, 32'hDEAD_BEEF);

        // Partial store hit merges low half.
        doStore(32'h0000_0100, 32'h1122_3344, 4'b0011, 2);
        doLoad(32'h0000_0100, 1'b0, 0, 32'h0, 32'hDEAD_3344);

        // Zero byte enables: memory transaction but no data change.
        doStore(32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, 1);
        doLoad(32'h0000_0100, 1'b0, 0, 32'h0, 32'hDEAD_3344);

        // Store miss does not allocate.
        doStore(32'h0000_0200, 32'hA5A5_A5A5, 4'b1111, 1);
        doLoad(32'h0000_0200, 1'b1, 2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // Conflict on index 0: different tags evict each other.
        doLoad(32'h0000_1100, 1'b1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        doLoad(32'h0000_0100, 1'b1, 2, 32'hDEAD_3344, 32'hDEAD_3344);

        // Reset during FILL with a coincident ack.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_1100;
        #1;
        check("rf_stall", cpu_stall, 1'b1);
        tick();
        check("rf_mem_req", mem_req, 1'b1);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("rf_mem_idle", {mem_req, mem_we}, 2'b00);
        check("rf_rdata", cpu_rdata, 32'h0);
        check("rf_idle_miss", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        #1;
        check("rf_idle", cpu_stall, 1'b0);
        tick();
        doLoad(32'h0000_1100, 1'b1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        doLoad(32'h0000_0100, 1'b1, 2, 32'hDEAD_3344, 32'hDEAD_3344);

        // Spurious ack in IDLE.
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        check("sp_stall", cpu_stall, 1'b0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("sp_idle", {cpu_stall, mem_req}, 2'b00);
        doLoad(32'h0000_0100, 1'b0, 0, 32'h0, 32'hDEAD_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
